// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multicycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ASHL = 3'b001,
    OP_XNOR = 3'b010,
    OP_ASHR = 3'b011,
    OP_SUB  = 3'b100,
    OP_DIV  = 3'b101,
    OP_NEG  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Ops whose result is formed in the accept cycle and go straight to DONE.
  function automatic logic is_single_cycle(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XNOR) ||
           (op == OP_NEG) || (op == OP_PASS);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH iterations.
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             take;

  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    // When the subtraction is taken the true remainder is below the divisor,
    // so the low WIDTH bits of the difference are exact.
    diff     = rem_sh[WIDTH-1:0] - div_q;
    take     = (rem_sh >= {1'b0, div_q});
    rem_step = take ? diff : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], take};

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The last step's quotient is offered combinationally so the caller can
  // register it on the same edge the final iteration completes.
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_step;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arithmetic/logic, iterative shifts, and
// unsigned division through alu_divider, with a valid/ready handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             zero,
  output logic             neg
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  op_e              in_op;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_co;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic             load;
  logic [WIDTH-1:0] res;
  logic             res_co;

  assign in_op  = op_e'(sel);
  assign sh_amt = (op2[SHW-1:0] > SHW'(WIDTH)) ? SHW'(WIDTH) : op2[SHW-1:0];

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (op1),
    .divisor_i  (op2),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    add_w  = {1'b0, op1} + {1'b0, op2};
    sc_res = op1;
    sc_co  = 1'b0;
    case (in_op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_co  = add_w[WIDTH];
      end
      OP_SUB: begin
        sc_res = op1 - op2;
        sc_co  = (op1 < op2);
      end
      OP_XNOR: sc_res = ~(op1 ^ op2);
      OP_NEG:  sc_res = -op1;
      default: sc_res = op1;
    endcase
  end

  always_comb begin
    if (op_q == OP_ASHL) begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
      sh_out  = sh_q[WIDTH-1];
    end else begin
      sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      sh_out  = sh_q[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    co_d      = co_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    div_start = 1'b0;
    load      = 1'b0;
    res       = sc_res;
    res_co    = sc_co;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          if (is_single_cycle(in_op)) begin
            load = 1'b1;
          end else if (in_op == OP_DIV) begin
            if (op2 == '0) begin
              load   = 1'b1;
              res    = '1;
              res_co = 1'b1;
            end else begin
              div_start = 1'b1;
              state_d   = ST_BUSY;
            end
          end else if (sh_amt == '0) begin
            load   = 1'b1;
            res    = op1;
            res_co = 1'b0;
          end else begin
            sh_d    = op1;
            cnt_d   = sh_amt;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (op_q == OP_DIV) begin
          if (div_done) begin
            load   = 1'b1;
            res    = div_quo;
            res_co = 1'b0;
          end
        end else begin
          // The final shift is captured directly into the result register.
          sh_d  = sh_next;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            load   = 1'b1;
            res    = sh_next;
            res_co = sh_out;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_DONE;
      out_d   = res;
      co_d    = res_co;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign co        = co_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter: SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from op2[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present on op1/op2/sel.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op1, op2  input  WIDTH each  operands (signed/unsigned per op).
REQ-008 sel  input  3  opcode: 000 ADD, 001 ASHL, 010 XNOR, 011 ASHR, 100 SUB, 101 DIV, 110 NEG, 111 PASS.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out  output  WIDTH  registered result.
REQ-012 co  output  1  carry/borrow/shift-out/div-by-zero flag per op.
REQ-013 zero, neg  output  1 each  out==0; out[WIDTH-1].

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Request accepted on in_valid&&in_ready; op1/op2/sel captured that edge; inputs ignored until return to IDLE.
REQ-016 ADD, SUB, XNOR, NEG, PASS: IDLE->DONE directly; out_valid asserted the cycle after accept (latency 1).
REQ-017 ADD: out=(op1+op2) mod 2^WIDTH, co=carry out of MSB.
REQ-018 SUB: out=(op1-op2) mod 2^WIDTH, co=1 when op1<op2 unsigned (borrow).
REQ-019 XNOR bitwise, co=0; NEG out=two's complement of op1, co=0; PASS out=op1, co=0.
REQ-020 ASHL/ASHR: n=min(op2[SHW-1:0],WIDTH); one bit shifted per BUSY cycle; n=0 goes IDLE->DONE (latency 1, out=op1, co=0); else latency n+1.
REQ-021 ASHL fills zeros at LSB; ASHR replicates sign bit; co=last bit shifted out.
REQ-022 DIV: unsigned restoring division, exactly WIDTH BUSY cycles, latency WIDTH+1; out=quotient, co=0.
REQ-023 DIV by zero: skip BUSY, latency 1, out=all ones, co=1.
REQ-024 DONE holds out/co/zero/neg stable until out_ready=1; then DONE->IDLE next edge; in_ready returns that cycle (no overlap of accept and unload).
REQ-025 zero/neg computed from final out, registered with it.

Reset
REQ-026 rst_n low: immediately state=IDLE, out=0, co=0, zero=0, neg=0, out_valid=0, in_ready=1 after release.
REQ-027 Reset mid-BUSY or mid-DONE aborts the operation; no result is delivered afterwards.
REQ-028 Iteration counters and shift/divide datapath registers are reset to 0.

Structure
REQ-029 Shared package alu_pkg holds opcode localparams/enum and FSM state enum.
REQ-030 Iterative divider is sub-module alu_divider (start, done, quotient), parametrised by WIDTH.
REQ-031 Shift iteration and single-cycle ops live in alu_multicycle; no combinational path in->out.

Verification (WIDTH=8)
REQ-032 ADD 0xF0+0x20 -> one cycle later out=0x10, co=1, zero=0, neg=0.
REQ-033 ASHR 0x80 by 3 -> out_valid 4 cycles after accept, out=0xF0, co=0, neg=1; ASHL 0x81 by 1 -> out=0x02, co=1, latency 2.
REQ-034 DIV 200/7 -> out_valid 9 cycles after accept, out=28; DIV 5/0 -> latency 1, out=0xFF, co=1.
REQ-035 out_ready held low 5 cycles in DONE -> out stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-036 rst_n asserted at BUSY cycle 4 of DIV -> out_valid=0, out=0 immediately, in_ready=1 after release, no stale result.
